// File: rtl/host_endpoint_hub_if.sv
// Host write bus between the host and the endpoint hub.
// HOST_READBACK_EN adds the combinational wire-in readback port pair.
interface host_endpoint_hub_if;
  logic        host_wr_en;
  logic [7:0]  host_addr;
  logic [31:0] host_data;
  logic        host_update;
`ifdef HOST_READBACK_EN
  logic [7:0]  host_rd_addr;
  logic [31:0] host_rd_data;
`endif

  modport master (
    output host_wr_en,
    output host_addr,
    output host_data,
    output host_update
`ifdef HOST_READBACK_EN
    ,
    output host_rd_addr,
    input  host_rd_data
`endif
  );

  modport slave (
    input  host_wr_en,
    input  host_addr,
    input  host_data,
    input  host_update
`ifdef HOST_READBACK_EN
    ,
    input  host_rd_addr,
    output host_rd_data
`endif
  );
endinterface

// File: rtl/host_endpoint_hub.sv
// Host endpoint decoder: shadowed wire-in registers committed on update, and
// single-cycle trigger-in pulses. Define HOST_READBACK_EN for wire readback.
module host_endpoint_hub #(
  parameter int         N_WIRE    = 2,
  parameter int         N_TRIG    = 2,
  parameter logic [7:0] WIRE_BASE = 8'h00,
  parameter logic [7:0] TRIG_BASE = 8'h40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  host_endpoint_hub_if.slave    host,
  output logic [32*N_WIRE-1:0]  wire_out,
  output logic [32*N_TRIG-1:0]  trig_out
);

  logic [32*N_WIRE-1:0] shadow_q, shadow_d;
  logic [32*N_WIRE-1:0] wire_q,   wire_d;
  logic [32*N_TRIG-1:0] trig_q,   trig_d;

  always_comb begin
    shadow_d = shadow_q;
    // Commit reads the pre-write shadow, so a same-cycle write waits for the next update.
    wire_d   = host.host_update ? shadow_q : wire_q;
    trig_d   = '0;
    for (int i = 0; i < N_WIRE; i++) begin
      if (host.host_wr_en && (host.host_addr == WIRE_BASE + 8'(i))) begin
        shadow_d[32*i +: 32] = host.host_data;
      end
    end
    for (int j = 0; j < N_TRIG; j++) begin
      if (host.host_wr_en && (host.host_addr == TRIG_BASE + 8'(j))) begin
        trig_d[32*j +: 32] = host.host_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      wire_q   <= '0;
      trig_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      wire_q   <= wire_d;
      trig_q   <= trig_d;
    end
  end

  assign wire_out = wire_q;
  assign trig_out = trig_q;

`ifdef HOST_READBACK_EN
  // Only wire-in addresses decode; trigger and unmapped addresses read zero.
  always_comb begin
    host.host_rd_data = 32'h0;
    for (int i = 0; i < N_WIRE; i++) begin
      if (host.host_rd_addr == WIRE_BASE + 8'(i)) begin
        host.host_rd_data = wire_q[32*i +: 32];
      end
    end
  end
`endif

endmodule

// File: tb/tb_host_endpoint_hub.sv
// Scoreboard bench for host_endpoint_hub: a reference model pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_host_endpoint_hub;
  localparam int NW = 2;
  localparam int NT = 2;
  localparam int WB = 8'h00;
  localparam int TB = 8'h40;

  typedef struct {
    logic [32*NW-1:0] w;
    logic [32*NT-1:0] t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [32*NW-1:0] wire_out;
  logic [32*NT-1:0] trig_out;

  host_endpoint_hub_if hif ();

  host_endpoint_hub dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (hif),
    .wire_out (wire_out),
    .trig_out (trig_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];
  logic [31:0] m_shadow[NW];
  logic [31:0] m_wire[NW];
  logic [31:0] m_trig[NT];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_shadow[i] = '0;
      m_wire[i]   = '0;
    end
    for (int j = 0; j < NT; j++) m_trig[j] = '0;
    sb_q.delete();
  endtask

  // Drive one cycle, predict the registered outputs, then check them after the edge.
  task automatic step(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic upd);
    exp_t e;
    exp_t g;
    @(negedge clk);
    hif.host_wr_en  = wr;
    hif.host_addr   = addr;
    hif.host_data   = data;
    hif.host_update = upd;
    for (int j = 0; j < NT; j++)
      m_trig[j] = (wr && int'(addr) == TB + j) ? data : 32'h0;
    if (upd)
      for (int i = 0; i < NW; i++) m_wire[i] = m_shadow[i];
    if (wr)
      for (int i = 0; i < NW; i++)
        if (int'(addr) == WB + i) m_shadow[i] = data;
    for (int i = 0; i < NW; i++) e.w[32*i +: 32] = m_wire[i];
    for (int j = 0; j < NT; j++) e.t[32*j +: 32] = m_trig[j];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 64'd0, 64'd1);
    end else begin
      g = sb_q.pop_front();
      chk("sb_wire", 64'(wire_out), 64'(g.w));
      chk("sb_trig", 64'(trig_out), 64'(g.t));
    end
  endtask

  task automatic idle();
    step(1'b0, 8'hFF, 32'h0, 1'b0);
  endtask

  initial begin
    logic [7:0] addr_tbl[7];
    addr_tbl = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h41, 8'h42, 8'h80};
    hif.host_wr_en  = 1'b0;
    hif.host_addr   = 8'h00;
    hif.host_data   = 32'h0;
    hif.host_update = 1'b0;
`ifdef HOST_READBACK_EN
    hif.host_rd_addr = 8'h00;
`endif
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("reset_wire", 64'(wire_out), 64'd0);
    chk("reset_trig", 64'(trig_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wire write held in shadow until update
    step(1'b1, 8'h00, 32'h0000_0005, 1'b0);
    chk("wire0_no_update", 64'(wire_out[31:0]), 64'd0);
    step(1'b0, 8'h00, 32'h0, 1'b1);
    chk("wire0_update", 64'(wire_out[31:0]), 64'h5);
    idle();
    chk("wire0_held", 64'(wire_out[31:0]), 64'h5);
`ifdef HOST_READBACK_EN
    hif.host_rd_addr = 8'h00;
    #1;
    chk("rd_wire0", 64'(hif.host_rd_data), 64'h5);
    hif.host_rd_addr = 8'h40;
    #1;
    chk("rd_trig0", 64'(hif.host_rd_data), 64'h0);
`endif

    // Trigger pulses
    step(1'b1, 8'h40, 32'h0000_0001, 1'b0);
    chk("trig0_pulse", 64'(trig_out[0]), 64'd1);
    idle();
    chk("trig0_clear", 64'(trig_out[0]), 64'd0);
    step(1'b1, 8'h41, 32'h0000_0080, 1'b0);
    chk("trig39_pulse", 64'(trig_out[39]), 64'd1);
    idle();
    chk("trig39_clear", 64'(trig_out[39]), 64'd0);

    // Same-cycle update and write
    step(1'b1, 8'h01, 32'h3, 1'b0);
    step(1'b0, 8'h00, 32'h0, 1'b1);
    step(1'b1, 8'h01, 32'hA, 1'b1);
    chk("wire1_old_shadow", 64'(wire_out[63:32]), 64'h3);
    step(1'b0, 8'h00, 32'h0, 1'b1);
    chk("wire1_new", 64'(wire_out[63:32]), 64'hA);

    // Out-of-range writes, zero data, back-to-back triggers
    step(1'b1, 8'h02, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 8'h42, 32'hFFFF_FFFF, 1'b0);
    chk("oor_trig", 64'(trig_out), 64'd0);
    step(1'b1, 8'h40, 32'h0, 1'b0);
    chk("zero_data_trig", 64'(trig_out), 64'd0);
    step(1'b1, 8'h40, 32'h0000_0011, 1'b0);
    step(1'b1, 8'h40, 32'h0000_0022, 1'b0);
    chk("b2b_second", 64'(trig_out[31:0]), 64'h22);
    idle();

    // Random traffic
    for (int k = 0; k < 60; k++) begin
      step(1'($urandom_range(0, 1)), addr_tbl[$urandom_range(0, 6)], $urandom,
           ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a pulse clears outputs without a clock edge
    step(1'b1, 8'h41, 32'hFFFF_FFFF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midpulse_rst_trig", 64'(trig_out), 64'd0);
    chk("midpulse_rst_wire", 64'(wire_out), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 32'h0, 1'b1);
    chk("post_rst_shadow", 64'(wire_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
